// File: rtl/ft_lockstep_unit_pkg.sv
// Shared types and constants for the lockstep unit: FSM states, vote outcomes and error counter width.
// The error counter width is used only when FT_ERR_COUNTERS_EN is defined.
package ft_pkg;

  localparam int ERR_CNT_WIDTH = 16;
  localparam int RETRY_WIDTH   = 4;

  typedef enum logic [2:0] {
    RUN,
    HALT,
    REPLAY,
    RESUME,
    FAIL
  } state_t;

  typedef enum logic [1:0] {
    CLEAN,
    CORRECTED,
    UNCORRECTABLE
  } vote_t;

endpackage

// File: rtl/ft_lockstep_unit_if.sv
// Write-back bus between the redundant cores and the lockstep unit, plus the halt/replay/resume side.
// err_cnt_o exists only when FT_ERR_COUNTERS_EN is defined.
interface ft_lockstep_unit_if
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CORES  = 3
);

  logic [NUM_CORES-1:0]                 we_i;
  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] data_i;
  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] pc_i;
  logic                                 halt_o;
  logic                                 replay_valid_o;
  logic [ADDR_WIDTH-1:0]                replay_addr_o;
  logic [DATA_WIDTH-1:0]                replay_data_o;
  logic                                 resume_o;
  logic [DATA_WIDTH-1:0]                restore_pc_o;
  logic [NUM_CORES-1:0]                 fault_lane_o;
  logic                                 fail_o;

`ifdef FT_ERR_COUNTERS_EN
  logic [NUM_CORES-1:0][ERR_CNT_WIDTH-1:0] err_cnt_o;

  modport master (
    output we_i, addr_i, data_i, pc_i,
    input  halt_o, replay_valid_o, replay_addr_o, replay_data_o,
    input  resume_o, restore_pc_o, fault_lane_o, fail_o, err_cnt_o
  );

  modport slave (
    input  we_i, addr_i, data_i, pc_i,
    output halt_o, replay_valid_o, replay_addr_o, replay_data_o,
    output resume_o, restore_pc_o, fault_lane_o, fail_o, err_cnt_o
  );
`else
  modport master (
    output we_i, addr_i, data_i, pc_i,
    input  halt_o, replay_valid_o, replay_addr_o, replay_data_o,
    input  resume_o, restore_pc_o, fault_lane_o, fail_o
  );

  modport slave (
    input  we_i, addr_i, data_i, pc_i,
    output halt_o, replay_valid_o, replay_addr_o, replay_data_o,
    output resume_o, restore_pc_o, fault_lane_o, fail_o
  );
`endif

endinterface

// File: rtl/ft_lockstep_unit_voter.sv
// Combinational DMR/TMR vote over the lane write-back tuples {we, addr, data, pc}.
// Produces the vote outcome, the winning tuple and a mask of outvoted lanes.
module ft_voter
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CORES  = 3
) (
  input  logic [NUM_CORES-1:0]                 we,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] data,
  input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] pc,
  output vote_t                                result,
  output logic                                 voted_we,
  output logic [ADDR_WIDTH-1:0]                voted_addr,
  output logic [DATA_WIDTH-1:0]                voted_data,
  output logic [DATA_WIDTH-1:0]                voted_pc,
  output logic [NUM_CORES-1:0]                 minority
);

  // Address and data only matter when the lanes actually write.
  function automatic logic tuple_eq(
    input logic                  we_a,
    input logic                  we_b,
    input logic [ADDR_WIDTH-1:0] addr_a,
    input logic [ADDR_WIDTH-1:0] addr_b,
    input logic [DATA_WIDTH-1:0] data_a,
    input logic [DATA_WIDTH-1:0] data_b,
    input logic [DATA_WIDTH-1:0] pc_a,
    input logic [DATA_WIDTH-1:0] pc_b
  );
    return (we_a == we_b) && (pc_a == pc_b) &&
           (!we_a || ((addr_a == addr_b) && (data_a == data_b)));
  endfunction

  logic eq01;

  assign eq01 = tuple_eq(we[0], we[1], addr[0], addr[1], data[0], data[1], pc[0], pc[1]);

  if (NUM_CORES == 3) begin : g_tmr
    logic       eq02;
    logic       eq12;
    logic [1:0] sel;

    assign eq02 = tuple_eq(we[0], we[2], addr[0], addr[2], data[0], data[2], pc[0], pc[2]);
    assign eq12 = tuple_eq(we[1], we[2], addr[1], addr[2], data[1], data[2], pc[1], pc[2]);

    always_comb begin
      result   = UNCORRECTABLE;
      minority = '0;
      sel      = 2'd0;
      if (eq01 && eq02) begin
        result = CLEAN;
      end else if (eq01) begin
        result   = CORRECTED;
        minority = 3'b100;
      end else if (eq02) begin
        result   = CORRECTED;
        minority = 3'b010;
      end else if (eq12) begin
        result   = CORRECTED;
        minority = 3'b001;
        sel      = 2'd1;
      end
    end

    assign voted_we   = we[sel];
    assign voted_addr = addr[sel];
    assign voted_data = data[sel];
    assign voted_pc   = pc[sel];
  end else begin : g_dmr
    assign result     = eq01 ? CLEAN : UNCORRECTABLE;
    assign minority   = '0;
    assign voted_we   = we[0];
    assign voted_addr = addr[0];
    assign voted_data = data[0];
    assign voted_pc   = pc[0];
  end

endmodule

// File: rtl/ft_lockstep_unit.sv
// Lockstep checker: votes the lanes' write-back, keeps a shadow register file and checkpoint PC,
// and rolls the cores back by replaying the shadow on an uncorrectable mismatch. FT_ERR_COUNTERS_EN adds per-lane error counters.
module ft_lockstep_unit
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CORES   = 3,
  parameter int MAX_RETRIES = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  ft_lockstep_unit_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                  state_q;
  state_t                  state_d;
  logic [RETRY_WIDTH-1:0]  retry_q;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic [DATA_WIDTH-1:0]   ckpt_pc_q;
  logic [DATA_WIDTH-1:0]   shadow_q [DEPTH];
  logic [NUM_CORES-1:0]    fault_q;

  vote_t                   vote;
  logic                    voted_we;
  logic [ADDR_WIDTH-1:0]   voted_addr;
  logic [DATA_WIDTH-1:0]   voted_data;
  logic [DATA_WIDTH-1:0]   voted_pc;
  logic [NUM_CORES-1:0]    minority;

  logic                    commit;
  logic                    bad;
  logic                    give_up;

  ft_voter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CORES  (NUM_CORES)
  ) u_voter (
    .we         (bus.we_i),
    .addr       (bus.addr_i),
    .data       (bus.data_i),
    .pc         (bus.pc_i),
    .result     (vote),
    .voted_we   (voted_we),
    .voted_addr (voted_addr),
    .voted_data (voted_data),
    .voted_pc   (voted_pc),
    .minority   (minority)
  );

  assign commit  = (state_q == RUN) && (vote != UNCORRECTABLE);
  assign bad     = (state_q == RUN) && (vote == UNCORRECTABLE);
  assign give_up = (retry_q == RETRY_WIDTH'(MAX_RETRIES));

  always_comb begin
    state_d            = state_q;
    bus.halt_o         = 1'b0;
    bus.replay_valid_o = 1'b0;
    bus.resume_o       = 1'b0;
    bus.fail_o         = 1'b0;
    case (state_q)
      RUN: begin
        if (bad) state_d = give_up ? FAIL : HALT;
      end
      HALT: begin
        bus.halt_o = 1'b1;
        state_d    = REPLAY;
      end
      REPLAY: begin
        bus.halt_o         = 1'b1;
        bus.replay_valid_o = 1'b1;
        if (raddr_q == '1) state_d = RESUME;
      end
      RESUME: begin
        bus.resume_o = 1'b1;
        state_d      = RUN;
      end
      FAIL: begin
        bus.halt_o = 1'b1;
        bus.fail_o = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // The retry budget is refreshed only by real forward progress, i.e. an agreed register write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      retry_q   <= '0;
      raddr_q   <= '0;
      ckpt_pc_q <= '0;
      fault_q   <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= commit ? minority : '0;
      if (commit) ckpt_pc_q <= voted_pc;
      if (commit && voted_we) begin
        retry_q <= '0;
      end else if (bad && !give_up) begin
        retry_q <= retry_q + RETRY_WIDTH'(1);
      end
      if (state_q == REPLAY) raddr_q <= raddr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
    end else if (commit && voted_we) begin
      shadow_q[voted_addr] <= voted_data;
    end
  end

  assign bus.replay_addr_o = raddr_q;
  assign bus.replay_data_o = shadow_q[raddr_q];
  assign bus.restore_pc_o  = ckpt_pc_q;
  assign bus.fault_lane_o  = fault_q;

`ifdef FT_ERR_COUNTERS_EN
  logic [NUM_CORES-1:0][ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic [NUM_CORES-1:0]                    bump;

  // An uncorrectable vote cannot say who was wrong, so every lane is charged.
  assign bump = bad ? '1 : (commit ? minority : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (bump[i] && (err_cnt_q[i] != '1)) err_cnt_q[i] <= err_cnt_q[i] + ERR_CNT_WIDTH'(1);
      end
    end
  end

  assign bus.err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_ft_lockstep_unit.sv
// Self-checking bench for ft_lockstep_unit: a TMR instance scored against a cycle model, a DMR instance with directed checks.
// Error counter checks are compiled in when FT_ERR_COUNTERS_EN is defined.
module tb_ft_lockstep_unit;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int MAXR  = 3;
  localparam int DEPTH = 32;

  localparam int M_RUN    = 0;
  localparam int M_HALT   = 1;
  localparam int M_REPLAY = 2;
  localparam int M_RESUME = 3;
  localparam int M_FAIL   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  ft_lockstep_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CORES(3)) tmr_if ();
  ft_lockstep_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CORES(2)) dmr_if ();

  ft_lockstep_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CORES(3), .MAX_RETRIES(MAXR)) dut_tmr (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (tmr_if)
  );

  ft_lockstep_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CORES(2), .MAX_RETRIES(MAXR)) dut_dmr (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (dmr_if)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] pc;
  } tuple_t;

  typedef struct {
    logic          halt;
    logic          rv;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          resume;
    logic [DW-1:0] rpc;
    logic [2:0]    fault;
    logic          fail;
  } exp_t;

  tuple_t        lane [3];
  exp_t          sb [$];

  int            m_state;
  int            m_retry;
  logic [AW-1:0] m_raddr;
  logic [DW-1:0] m_pc;
  logic [DW-1:0] m_shadow [DEPTH];
  logic [2:0]    m_fault;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit tupleEq(input tuple_t a, input tuple_t b);
    return (a.we == b.we) && (a.pc == b.pc) && (!a.we || ((a.addr == b.addr) && (a.data == b.data)));
  endfunction

  function automatic void modelReset();
    m_state = M_RUN;
    m_retry = 0;
    m_raddr = '0;
    m_pc    = '0;
    m_fault = '0;
    for (int i = 0; i < DEPTH; i++) m_shadow[i] = '0;
  endfunction

  // Majority by counting how many lanes agree with each lane.
  function automatic void modelStep();
    int votes [3];
    int best;
    m_fault = '0;
    case (m_state)
      M_RUN: begin
        best = 0;
        for (int i = 0; i < 3; i++) begin
          votes[i] = 0;
          for (int j = 0; j < 3; j++) if (tupleEq(lane[i], lane[j])) votes[i]++;
        end
        for (int i = 0; i < 3; i++) if (votes[i] > votes[best]) best = i;
        if (votes[best] >= 2) begin
          if (votes[best] == 2) for (int i = 0; i < 3; i++) if (votes[i] == 1) m_fault[i] = 1'b1;
          if (lane[best].we) begin
            m_shadow[lane[best].addr] = lane[best].data;
            m_retry = 0;
          end
          m_pc = lane[best].pc;
        end else if (m_retry == MAXR) begin
          m_state = M_FAIL;
        end else begin
          m_retry++;
          m_state = M_HALT;
        end
      end
      M_HALT:   m_state = M_REPLAY;
      M_REPLAY: begin
        if (m_raddr == AW'(DEPTH - 1)) m_state = M_RESUME;
        m_raddr = m_raddr + 1'b1;
      end
      M_RESUME: m_state = M_RUN;
      default:  ;
    endcase
  endfunction

  function automatic exp_t expectNow();
    exp_t e;
    e.halt   = (m_state == M_HALT) || (m_state == M_REPLAY) || (m_state == M_FAIL);
    e.rv     = (m_state == M_REPLAY);
    e.raddr  = m_raddr;
    e.rdata  = m_shadow[m_raddr];
    e.resume = (m_state == M_RESUME);
    e.rpc    = m_pc;
    e.fault  = m_fault;
    e.fail   = (m_state == M_FAIL);
    return e;
  endfunction

  task automatic setLane(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] p);
    lane[i].we   = we;
    lane[i].addr = a;
    lane[i].data = d;
    lane[i].pc   = p;
  endtask

  task automatic setAll(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] p);
    for (int i = 0; i < 3; i++) setLane(i, we, a, d, p);
  endtask

  task automatic setDmr(input int i, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] p);
    dmr_if.we_i[i]   = we;
    dmr_if.addr_i[i] = a;
    dmr_if.data_i[i] = d;
    dmr_if.pc_i[i]   = p;
  endtask

  task automatic driveTmr();
    for (int i = 0; i < 3; i++) begin
      tmr_if.we_i[i]   = lane[i].we;
      tmr_if.addr_i[i] = lane[i].addr;
      tmr_if.data_i[i] = lane[i].data;
      tmr_if.pc_i[i]   = lane[i].pc;
    end
  endtask

  task automatic checkTmr();
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput("halt",         tmr_if.halt_o,         e.halt);
    checkOutput("replay_valid", tmr_if.replay_valid_o, e.rv);
    checkOutput("replay_addr",  tmr_if.replay_addr_o,  e.raddr);
    checkOutput("replay_data",  tmr_if.replay_data_o,  e.rdata);
    checkOutput("resume",       tmr_if.resume_o,       e.resume);
    checkOutput("restore_pc",   tmr_if.restore_pc_o,   e.rpc);
    checkOutput("fault_lane",   tmr_if.fault_lane_o,   e.fault);
    checkOutput("fail",         tmr_if.fail_o,         e.fail);
  endtask

  task automatic applyStimulus();
    driveTmr();
    modelStep();
    sb.push_back(expectNow());
    @(posedge clk);
    #1;
    checkTmr();
  endtask

  task automatic doReset();
    rst = 1'b1;
    setAll(1'b0, '0, '0, '0);
    driveTmr();
    setDmr(0, 1'b0, '0, '0, '0);
    setDmr(1, 1'b0, '0, '0, '0);
    modelReset();
    sb.push_back(expectNow());
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkTmr();
  endtask

  task automatic allDifferent(input logic [DW-1:0] p);
    setLane(0, 1'b1, 5'd3, 32'h1, p);
    setLane(1, 1'b1, 5'd3, 32'h2, p);
    setLane(2, 1'b1, 5'd3, 32'h3, p);
  endtask

  initial begin
    $display("[TB] start");
    doReset();

    // DMR: one agreed write, then a data mismatch and a full rollback.
    setDmr(0, 1'b1, 5'd7, 32'h55, 32'h200);
    setDmr(1, 1'b1, 5'd7, 32'h55, 32'h200);
    @(posedge clk); #1;
    checkOutput("dmr_clean_halt", dmr_if.halt_o, 1'b0);
    setDmr(0, 1'b1, 5'd7, 32'h66, 32'h204);
    setDmr(1, 1'b1, 5'd7, 32'h77, 32'h204);
    @(posedge clk); #1;
    checkOutput("dmr_halt", dmr_if.halt_o, 1'b1);
    checkOutput("dmr_halt_rv", dmr_if.replay_valid_o, 1'b0);
    setDmr(0, 1'b1, 5'd1, 32'h99, 32'h208);
    setDmr(1, 1'b1, 5'd1, 32'h99, 32'h208);
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      checkOutput("dmr_replay_valid", dmr_if.replay_valid_o, 1'b1);
      checkOutput("dmr_replay_addr", dmr_if.replay_addr_o, i);
      checkOutput("dmr_replay_data", dmr_if.replay_data_o, (i == 7) ? 32'h55 : 32'h0);
    end
    @(posedge clk); #1;
    checkOutput("dmr_resume", dmr_if.resume_o, 1'b1);
    checkOutput("dmr_restore_pc", dmr_if.restore_pc_o, 32'h200);
    checkOutput("dmr_resume_halt", dmr_if.halt_o, 1'b0);
    setDmr(0, 1'b0, '0, '0, 32'h20C);
    setDmr(1, 1'b0, '0, '0, 32'h20C);
    @(posedge clk); #1;
    checkOutput("dmr_run_resume", dmr_if.resume_o, 1'b0);
    checkOutput("dmr_run_halt", dmr_if.halt_o, 1'b0);

    // TMR: reset state, clean write, forced rollback.
    doReset();
    checkOutput("rst_replay_data", tmr_if.replay_data_o, 32'h0);
    checkOutput("rst_halt", tmr_if.halt_o, 1'b0);
    setAll(1'b1, 5'd3, 32'hDEADBEEF, 32'h100);
    applyStimulus();
    checkOutput("t1_no_halt", tmr_if.halt_o, 1'b0);
    allDifferent(32'h104);
    applyStimulus();
    checkOutput("t1_halt", tmr_if.halt_o, 1'b1);
    setAll(1'b0, '0, '0, 32'h104);
    for (int k = 0; k < 4; k++) applyStimulus();
    checkOutput("t1_replay_addr3", tmr_if.replay_addr_o, 32'd3);
    checkOutput("t1_replay_data3", tmr_if.replay_data_o, 32'hDEADBEEF);
    checkOutput("t1_restore_pc", tmr_if.restore_pc_o, 32'h100);
    for (int k = 0; k < 29; k++) applyStimulus();
    checkOutput("t1_resume", tmr_if.resume_o, 1'b1);
    applyStimulus();

    // TMR correction: lane 1 outvoted.
    setAll(1'b1, 5'd5, 32'h2, 32'h108);
    setLane(1, 1'b1, 5'd5, 32'h1, 32'h108);
    applyStimulus();
    checkOutput("t2_fault_lane", tmr_if.fault_lane_o, 3'b010);
    checkOutput("t2_no_halt", tmr_if.halt_o, 1'b0);
    setLane(0, 1'b0, 5'd11, 32'h11, 32'h10C);
    setLane(1, 1'b0, 5'd12, 32'h22, 32'h10C);
    setLane(2, 1'b0, 5'd13, 32'h33, 32'h10C);
    applyStimulus();
    checkOutput("t2_fault_clear", tmr_if.fault_lane_o, 3'b000);
    checkOutput("t2_nowrite_no_halt", tmr_if.halt_o, 1'b0);

    // Three rollbacks, then the fourth consecutive mismatch is terminal.
    for (int r = 0; r < 3; r++) begin
      allDifferent(32'h200 + r);
      applyStimulus();
      checkOutput("t3_halt", tmr_if.halt_o, 1'b1);
      setAll(1'b0, '0, '0, 32'h300);
      for (int k = 0; k < 34; k++) begin
        applyStimulus();
        if (r == 0 && k == 3) checkOutput("t3_shadow3", tmr_if.replay_data_o, 32'hDEADBEEF);
        if (r == 0 && k == 5) checkOutput("t3_shadow5", tmr_if.replay_data_o, 32'h2);
      end
      allDifferent(32'h210 + r);
    end
    applyStimulus();
    checkOutput("t3_fail", tmr_if.fail_o, 1'b1);
    checkOutput("t3_fail_halt", tmr_if.halt_o, 1'b1);
    checkOutput("t3_fail_no_replay", tmr_if.replay_valid_o, 1'b0);
    setAll(1'b1, 5'd4, 32'h77, 32'h400);
    for (int k = 0; k < 3; k++) applyStimulus();
    checkOutput("t3_fail_sticky", tmr_if.fail_o, 1'b1);
    checkOutput("t3_fail_pc_kept", tmr_if.restore_pc_o, 32'h10C);

    // Reset in the middle of a replay.
    doReset();
    setAll(1'b1, 5'd10, 32'hA5A5, 32'h500);
    applyStimulus();
    allDifferent(32'h504);
    applyStimulus();
    setAll(1'b0, '0, '0, 32'h508);
    for (int k = 0; k < 11; k++) applyStimulus();
    checkOutput("t4_at_addr10", tmr_if.replay_addr_o, 32'd10);
    checkOutput("t4_data10", tmr_if.replay_data_o, 32'hA5A5);
    doReset();
    checkOutput("t4_rst_halt", tmr_if.halt_o, 1'b0);
    checkOutput("t4_rst_rv", tmr_if.replay_valid_o, 1'b0);
    checkOutput("t4_rst_addr", tmr_if.replay_addr_o, 32'd0);
    checkOutput("t4_rst_pc", tmr_if.restore_pc_o, 32'h0);
    allDifferent(32'h600);
    applyStimulus();
    setAll(1'b0, '0, '0, 32'h604);
    for (int k = 0; k < 34; k++) begin
      applyStimulus();
      if (k == 10) checkOutput("t4_shadow10_zero", tmr_if.replay_data_o, 32'h0);
    end

`ifdef FT_ERR_COUNTERS_EN
    doReset();
    allDifferent(32'h700);
    applyStimulus();
    setAll(1'b0, '0, '0, 32'h704);
    for (int k = 0; k < 34; k++) applyStimulus();
    checkOutput("cnt_all_lane0", tmr_if.err_cnt_o[0], 32'd1);
    checkOutput("cnt_all_lane2", tmr_if.err_cnt_o[2], 32'd1);
    doReset();
    setAll(1'b1, 5'd1, 32'h11, 32'h800);
    setLane(2, 1'b1, 5'd1, 32'h12, 32'h800);
    for (int k = 0; k < 5; k++) applyStimulus();
    checkOutput("cnt_lane0", tmr_if.err_cnt_o[0], 32'd0);
    checkOutput("cnt_lane1", tmr_if.err_cnt_o[1], 32'd0);
    checkOutput("cnt_lane2", tmr_if.err_cnt_o[2], 32'd5);
    for (int k = 0; k < 65530; k++) applyStimulus();
    checkOutput("cnt_lane2_max", tmr_if.err_cnt_o[2], 32'hFFFF);
    for (int k = 0; k < 3; k++) applyStimulus();
    checkOutput("cnt_lane2_sat", tmr_if.err_cnt_o[2], 32'hFFFF);
    checkOutput("cnt_lane0_sat", tmr_if.err_cnt_o[0], 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ft_lockstep_unit.md
# ft_lockstep_unit

Parametrised successor to the lockstep fault-tolerance module: compares the write-back streams of NUM_CORES redundant cores (DMR or TMR), commits agreed results into a shadow register file plus checkpoint PC, and on an uncorrectable mismatch halts the cores and replays the shadow state before resuming. Adds TMR majority correction, a bounded retry counter with a terminal FAIL state, and optional per-lane error statistics. It sits beside the cores' write-back stage and drives the fetch-block halt/resume signals.

## Interface
- ADDR_WIDTH, 5, register address width; shadow depth 2**ADDR_WIDTH
- DATA_WIDTH, 32, register data and PC width
- NUM_CORES, 3, redundant lanes; legal values 2 (DMR) or 3 (TMR)
- MAX_RETRIES, 3, consecutive rollbacks tolerated before FAIL; range 1..15
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  reset, synchronous and active-high
- we_i  in  NUM_CORES  per-lane write enable
- addr_i  in  NUM_CORES x ADDR_WIDTH  per-lane write address
- data_i  in  NUM_CORES x DATA_WIDTH  per-lane write data
- pc_i  in  NUM_CORES x DATA_WIDTH  per-lane PC of the writing instruction
- halt_o  out  1  cores must stall
- replay_valid_o  out  1  replay_addr_o/replay_data_o valid
- replay_addr_o  out  ADDR_WIDTH  register being restored
- replay_data_o  out  DATA_WIDTH  shadow contents of that register
- resume_o  out  1  one-cycle pulse: restart from restore_pc_o
- restore_pc_o  out  DATA_WIDTH  checkpoint PC
- fault_lane_o  out  NUM_CORES  one-cycle pulse, lane outvoted (TMR only)
- fail_o  out  1  sticky unrecoverable fault
- err_cnt_o  out  NUM_CORES x 16  per-lane error counts (FT_ERR_COUNTERS_EN only)

## Operation
- Lane tuple = {we, addr, data, pc}; when we=0 only we and pc are compared.
- Vote (RUN only): all tuples equal -> CLEAN; TMR with exactly two equal -> CORRECTED, majority tuple used, minority lane flagged; otherwise (any DMR mismatch, TMR all-different) -> UNCORRECTABLE.
- CLEAN/CORRECTED: if voted we=1 write data to shadow[addr]; always load checkpoint PC with voted pc; if voted we=1 clear retry counter.
- UNCORRECTABLE: no shadow or PC write; if retry count == MAX_RETRIES go FAIL, else increment counter and go HALT.
- States: RUN -> HALT (1 cycle) -> REPLAY (2**ADDR_WIDTH cycles, addr counter 0..max, wraps to 0 on exit) -> RESUME (1 cycle) -> RUN. FAIL absorbing until rst_i.
- Inputs ignored outside RUN (no compare, no writes, no fault flags).
- halt_o = 1 in HALT, REPLAY, FAIL; 0 in RUN, RESUME. replay_valid_o = 1 only in REPLAY. resume_o = 1 only in RESUME. fail_o = 1 only in FAIL.
- replay_data_o always reflects shadow[replay_addr_o] combinationally.
- Reset: state RUN, retry counter 0, replay addr 0, checkpoint PC 0, all shadow entries 0; all outputs 0 (replay_data_o = 0 via shadow reset).
- rst_i asserted in any state aborts immediately; next cycle is RUN.

## Timing
- Vote combinational on inputs of cycle t; shadow/PC/state update at edge ending t.
- Mismatch in t -> halt_o high in t+1; REPLAY t+2..t+1+2**ADDR_WIDTH; resume_o in t+2+2**ADDR_WIDTH; RUN (compare active) in t+3+2**ADDR_WIDTH.
- Commit in cycle t readable via replay port from t+1.
- fault_lane_o registered: CORRECTED in t -> pulse in t+1.
- Mismatch while counter == MAX_RETRIES -> fail_o and halt_o high from t+1, no replay.

## Configuration
- FT_ERR_COUNTERS_EN defined: per-lane 16-bit saturating counters (hold at 0xFFFF) increment on each cycle that lane is outvoted (TMR) or, for UNCORRECTABLE, all lanes increment; cleared only by rst_i; drive err_cnt_o.
- Undefined: counters and err_cnt_o port absent; all other behaviour identical.

## Structure
- Package ft_pkg: state enum (RUN, HALT, REPLAY, RESUME, FAIL), vote-result enum (CLEAN, CORRECTED, UNCORRECTABLE), counter width constant ERR_CNT_WIDTH = 16.
- Sub-module ft_voter: combinational NUM_CORES-lane comparison, outputs vote result, voted tuple, minority-lane mask.
- Shadow register file, FSM, retry/replay counters, PC checkpoint in top.

## Test plan
- TMR, all lanes write addr 3 = 0xDEADBEEF, pc 0x100 -> no halt; next cycle replay port addr 3 reads 0xDEADBEEF after forced rollback; restore_pc_o = 0x100.
- TMR, lane 1 data 0x1 vs others 0x2 at addr 5 -> shadow[5] = 0x2, fault_lane_o = 3'b010 one cycle, halt_o stays 0.
- DMR (NUM_CORES=2), data mismatch -> halt_o next cycle, replay_valid_o 32 cycles addr 0..31, resume_o one pulse, restore_pc_o = last agreed pc, shadow unchanged.
- MAX_RETRIES=3, four consecutive mismatches without intervening clean write -> three replays, fourth goes FAIL: fail_o=1, halt_o=1 until rst_i.
- rst_i asserted at REPLAY addr 10 -> next cycle RUN, all outputs 0, shadow zero.
- FT_ERR_COUNTERS_EN, lane 2 outvoted 5 times -> err_cnt_o lane 2 = 5, others 0; saturation holds at 0xFFFF.
